// File: rtl/obstacle_avoid_ctrl.sv
// obstacle_avoid_ctrl
//   Samples the ranging-stage distance on a fixed tick, confirms obstacles
//   with consecutive-sample counting plus a NEAR/CLEAR hysteresis band, and
//   runs the forward / stop / back-off / turn / re-check avoidance FSM with
//   bounded retries before halting.
//
// Optional build macro: OBSTACLE_MEDIAN_EN
//   When defined, valid samples pass through a 3-entry median filter before
//   the NEAR/CLEAR comparison (one extra cycle between tick and counter
//   update). When undefined the raw sample is compared directly.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   enable     1 = autonomous driving permitted (0 forces IDLE)
//   distance   16-bit distance in mm, 0 = no echo (invalid sample)
//   motor_cmd  000 stop, 001 fwd, 010 back, 011 turn left, 100 turn right
//   state      0 IDLE, 1 FWD, 2 STOP, 3 BACK, 4 TURN, 5 CHECK, 6 HALT
//   obstacle   confirmed-obstacle flag
module obstacle_avoid_ctrl #(
    parameter int SAMPLE_DIV  = 5000000,
    parameter int NEAR_MM     = 200,
    parameter int CLEAR_MM    = 300,
    parameter int CONFIRM     = 3,
    parameter int STOP_CYC    = 5000000,
    parameter int BACK_CYC    = 25000000,
    parameter int TURN_CYC    = 35000000,
    parameter int CHECK_TICKS = 4,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] distance,
    output logic [2:0]  motor_cmd,
    output logic [2:0]  state,
    output logic        obstacle
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FWD   = 3'd1,
        S_STOP  = 3'd2,
        S_BACK  = 3'd3,
        S_TURN  = 3'd4,
        S_CHECK = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int CW = (CHECK_TICKS > 1) ? $clog2(CHECK_TICKS + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(SAMPLE_DIV - 1);
    localparam logic [15:0]   NEAR_V     = 16'(NEAR_MM);
    localparam logic [15:0]   CLEAR_V    = 16'(CLEAR_MM);
    localparam logic [2:0]    CONF       = 3'(CONFIRM);
    localparam logic [25:0]   STOP_LAST  = 26'(STOP_CYC - 1);
    localparam logic [25:0]   BACK_LAST  = 26'(BACK_CYC - 1);
    localparam logic [25:0]   TURN_LAST  = 26'(TURN_CYC - 1);
    localparam logic [CW-1:0] CHK_LAST   = CW'(CHECK_TICKS - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    localparam logic [2:0] CMD_STOP  = 3'b000;
    localparam logic [2:0] CMD_FWD   = 3'b001;
    localparam logic [2:0] CMD_BACK  = 3'b010;
    localparam logic [2:0] CMD_LEFT  = 3'b011;
    localparam logic [2:0] CMD_RIGHT = 3'b100;

    // ------------------------------------------------------------------
    // Sample tick
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    // ------------------------------------------------------------------
    // Sample source: raw or median-of-3
    // ------------------------------------------------------------------
    logic        samp_vld;
    logic [15:0] samp_val;

`ifdef OBSTACLE_MEDIAN_EN
    function automatic logic [15:0] med3(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [15:0] c);
        logic [15:0] lo, hi, m;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        m  = (hi < c) ? hi : c;
        return (lo > m) ? lo : m;
    endfunction

    logic [2:0][15:0] hist;
    logic             med_pend;

    // History only takes valid samples; the median is evaluated the cycle
    // after the shift so the comparison sees the updated window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist     <= {3{16'hFFFF}};
            med_pend <= 1'b0;
        end else begin
            med_pend <= tick && (distance != 16'd0);
            if (tick && (distance != 16'd0))
                hist <= {hist[1:0], distance};
        end
    end

    assign samp_vld = med_pend;
    assign samp_val = med3(hist[0], hist[1], hist[2]);
`else
    assign samp_vld = tick && (distance != 16'd0);
    assign samp_val = distance;
`endif

    // ------------------------------------------------------------------
    // Confirmation counters and obstacle flag
    // ------------------------------------------------------------------
    logic [2:0] near_cnt, far_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            near_cnt <= '0;
            far_cnt  <= '0;
            obstacle <= 1'b0;
        end else begin
            if (samp_vld) begin
                if (samp_val < NEAR_V) begin
                    near_cnt <= (near_cnt == CONF) ? near_cnt : near_cnt + 3'd1;
                    far_cnt  <= '0;
                end else if (samp_val >= CLEAR_V) begin
                    far_cnt  <= (far_cnt == CONF) ? far_cnt : far_cnt + 3'd1;
                    near_cnt <= '0;
                end
                // hysteresis band: both counters hold
            end
            // A near sample zeroes far_cnt and vice versa, so both cannot
            // sit at CONF together.
            if (near_cnt == CONF)     obstacle <= 1'b1;
            else if (far_cnt == CONF) obstacle <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Avoidance FSM
    // ------------------------------------------------------------------
    state_t        st, nxt;
    logic [25:0]   timer;
    logic [RW-1:0] retry;
    logic [CW-1:0] chk_cnt;
    logic          turn_dir;
    logic          chk_fail;

    assign state = st;

    always_comb begin
        nxt      = st;
        chk_fail = 1'b0;
        if (!enable) begin
            nxt = S_IDLE;
        end else begin
            case (st)
                S_IDLE:  nxt = S_FWD;
                S_FWD:   if (obstacle) nxt = S_STOP;
                S_STOP:  if (timer == STOP_LAST) nxt = S_BACK;
                S_BACK:  if (timer == BACK_LAST) nxt = S_TURN;
                S_TURN:  if (timer == TURN_LAST) nxt = S_CHECK;
                S_CHECK: begin
                    if (tick) begin
                        if (!obstacle) begin
                            nxt = S_FWD;
                        end else if (chk_cnt == CHK_LAST) begin
                            chk_fail = 1'b1;
                            nxt      = (retry == RETRY_LAST) ? S_HALT : S_BACK;
                        end
                    end
                end
                S_HALT:  nxt = S_HALT;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= S_IDLE;
            timer     <= '0;
            retry     <= '0;
            chk_cnt   <= '0;
            turn_dir  <= 1'b0;
            motor_cmd <= CMD_STOP;
        end else begin
            st <= nxt;

            if (nxt != st) timer <= '0;
            else           timer <= timer + 26'd1;

            if (nxt != st)                  chk_cnt <= '0;
            else if (st == S_CHECK && tick) chk_cnt <= chk_cnt + CW'(1);

            if (nxt == S_FWD && (st == S_IDLE || st == S_CHECK)) retry <= '0;
            else if (chk_fail)                                   retry <= retry + RW'(1);

            // turn_dir names the direction of the upcoming turn; it flips as
            // that turn starts so the following one goes the other way.
            if (nxt == S_TURN && st != S_TURN) turn_dir <= ~turn_dir;

            case (nxt)
                S_FWD:   motor_cmd <= CMD_FWD;
                S_BACK:  motor_cmd <= CMD_BACK;
                S_TURN:  if (st != S_TURN) motor_cmd <= turn_dir ? CMD_RIGHT : CMD_LEFT;
                default: motor_cmd <= CMD_STOP;
            endcase
        end
    end

endmodule
